// File: rtl/vg64_pkg.sv
// Shared definitions for the vg64 video SRAM path: memory geometry,
// read-back FSM encoding and the idle levels of the SRAM control strobes.
package vg64_pkg;

    localparam int VRAM_AW = 17;
    localparam int VRAM_DW = 8;

    localparam logic CE_N_IDLE = 1'b1;
    localparam logic OE_N_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SLOT = 3'd1,
        DRIVE     = 3'd2,
        HOLD      = 3'd3,
        CAPTURE   = 3'd4
    } rb_state_t;

endpackage

// File: rtl/tgl_sync.sv
// Three-flop synchronizer for a toggle-encoded request; evt pulses for one
// clk cycle per level change of tgl_in. All flops run on the falling edge.
module tgl_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tgl_in,
    output logic evt
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = tgl_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign evt = s2_q ^ s3_q;

endmodule

// File: rtl/vram_readback.sv
// C64 read-back engine: waits for a free SRAM window, performs one read and
// holds the byte for the bus-register side. Runs on the falling edge of clk25.
module vram_readback
    import vg64_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk25,
    input  logic          rst,
    input  logic          req_tgl,
    input  logic [AW-1:0] req_addr,
    input  logic          autoinc,
    input  logic          slot,
    input  logic          ovr_clr,
    input  logic [DW-1:0] sram_din,
    output logic          sram_own,
    output logic [AW-1:0] sram_addr,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW-1:0] rd_ptr,
    output logic          overrun
);

    logic req_evt;

    tgl_sync u_req_sync (
        .clk    (clk25),
        .rst_n  (rst),
        .tgl_in (req_tgl),
        .evt    (req_evt)
    );

    rb_state_t     state_q, state_d;
    logic [AW-1:0] fetch_q, fetch_d;
    logic          own_q, own_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        fetch_d = fetch_q;
        own_d   = own_q;
        addr_d  = addr_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        data_d  = data_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
                if (req_evt) begin
                    state_d = WAIT_SLOT;
                    fetch_d = autoinc ? ptr_q : req_addr;
                    valid_d = 1'b0;
                end
            end
            WAIT_SLOT: begin
                if (slot) state_d = DRIVE;
            end
            // Strobes are registered here, so the SRAM sees them one edge
            // after the slot was taken and for exactly two cycles.
            DRIVE: begin
                own_d   = 1'b1;
                addr_d  = fetch_q;
                ce_n_d  = 1'b0;
                oe_n_d  = 1'b0;
                state_d = HOLD;
            end
            HOLD: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d  = sram_din;
                valid_d = 1'b1;
                ptr_d   = fetch_q + AW'(1);
                own_d   = 1'b0;
                ce_n_d  = CE_N_IDLE;
                oe_n_d  = OE_N_IDLE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh overrun beats a coincident clear.
        if (ovr_clr) ovr_d = 1'b0;
        if (req_evt && (state_q != IDLE)) ovr_d = 1'b1;
    end

    always_ff @(negedge clk25 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            fetch_q <= '0;
            own_q   <= 1'b0;
            addr_q  <= '0;
            ce_n_q  <= CE_N_IDLE;
            oe_n_q  <= OE_N_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            own_q   <= own_d;
            addr_q  <= addr_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sram_own  = own_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign rd_data   = data_q;
    assign rd_valid  = valid_q;
    assign rd_ptr    = ptr_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/vram_readback.md
# vram_readback

Read-back engine that lets the C64 fetch bytes from the 128 KB video SRAM. It sits in the 25 MHz pixel-clock domain beside the display/write sequencer. It accepts a toggle-encoded read request from the C64 bus-register logic and waits for a free SRAM window announced by the sequencer. It then performs one SRAM read and holds the byte in a result register for the C64 register file to return on a later bus read.

## Interface
Parameters:
- AW, 17, SRAM address width ({bank, addr[15:0]})
- DW, 8, SRAM data width

Ports:
- clk25  in  1  pixel clock; all logic on negedge clk25
- rst  in  1  asynchronous, active-low reset
- req_tgl  in  1  request toggle from C64 domain; each level change = one read request; C64 side resets it to 0
- req_addr  in  AW  fetch address; stable from toggle change until rd_valid
- autoinc  in  1  1 = fetch from internal pointer instead of req_addr (sampled when request detected)
- slot  in  1  one-cycle pulse: SRAM free for the next 3 cycles
- ovr_clr  in  1  one-cycle pulse, clears overrun
- sram_din  in  DW  SRAM data (already registered in clk100 domain)
- sram_own  out  1  1 = this block drives SRAM address/controls
- sram_addr  out  AW  SRAM address while sram_own
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- rd_data  out  DW  last fetched byte
- rd_valid  out  1  rd_data is current for latest request
- rd_ptr  out  AW  next autoinc address
- overrun  out  1  sticky: request arrived while busy

## Operation
- Synchronizer: req_tgl → s1 → s2 → s3; req_evt = s2 ^ s3.
- States: IDLE, WAIT_SLOT, DRIVE, HOLD, CAPTURE.
- IDLE: on req_evt → WAIT_SLOT. Fetch address is latched as req_addr when autoinc=0, or rd_ptr when autoinc=1. rd_valid is cleared in the same edge.
- WAIT_SLOT: on slot → DRIVE. No timeout applies.
- DRIVE: sram_own=1, sram_addr=fetch address, ce_n=0, oe_n=0 → HOLD.
- HOLD: controls unchanged → CAPTURE.
- CAPTURE: rd_data ← sram_din, rd_valid ← 1, rd_ptr ← fetch address + 1 (wraps 17'h1FFFF → 0). Controls released (own=0, ce_n=1, oe_n=1) on this edge → IDLE.
- A req_evt in any state other than IDLE is dropped and sets overrun. The in-flight fetch continues unaffected.
- ovr_clr clears overrun. A simultaneous new overrun event wins, so overrun stays 1.
- A slot pulse outside WAIT_SLOT is ignored.
- sram_addr holds its last value when not owned. The sequencer muxes on sram_own.

## Timing
- Reset values: state IDLE, s1/s2/s3=0, sram_own=0, sram_addr=0, sram_ce_n=1, sram_oe_n=1, rd_data=0, rd_valid=0, rd_ptr=0, overrun=0.
- Reset mid-fetch returns the SRAM controls to idle immediately (asynchronous) and aborts the fetch.
- Request latency: req_tgl change → req_evt at the 3rd clk25 edge → WAIT_SLOT at that edge.
- Slot latency: slot high at edge t → DRIVE outputs valid after t+1. SRAM is driven for 2 cycles (80 ns). Capture happens at t+3, and rd_valid=1 after t+3.
- Best-case request-to-valid: 3 + 1 + 3 = 7 cycles when the slot is coincident.
- Minimum spacing between requests without overrun equals the request-to-valid time. The C64 (≥1 µs per cycle) meets this when a slot occurs every 8 cycles.

## Structure
- Shared package vg64_pkg holds:
  - VRAM_AW=17, VRAM_DW=8
  - the rb_state_t enum (IDLE, WAIT_SLOT, DRIVE, HOLD, CAPTURE)
  - SRAM control idle constants (CE_N_IDLE=1, OE_N_IDLE=1)
- Sub-module tgl_sync: 3-flop toggle synchronizer with req_evt output, reusable for the write-request path.

## Test plan
- Basic read: preload SRAM[17'h00123]=8'hA5. Toggle req_tgl with autoinc=0, then pulse slot 5 cycles later. Required response: ce_n/oe_n low for exactly 2 cycles with sram_addr=17'h00123, then rd_data=8'hA5, rd_valid=1, rd_ptr=17'h00124.
- Autoinc burst: first a non-inc read at 17'h0FFFF, then 3 autoinc requests. Required response: fetch addresses 17'h10000, 17'h10001, 17'h10002 (bank bit carries), with matching data.
- Wrap: read at 17'h1FFFF → rd_ptr=17'h00000, and the next autoinc fetch uses address 0.
- Overrun: a second toggle while in WAIT_SLOT → overrun=1 and only one SRAM access occurs. ovr_clr asserted in the same cycle as a new overrun event → overrun stays 1. ovr_clr alone → 0.
- Slot gating: slot pulses while IDLE or HOLD cause no SRAM activity and no extra fetch.
- Async reset during HOLD: ce_n=oe_n=1 and sram_own=0 before the next clock edge. After release, state is IDLE and rd_valid=0.
